// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, flag bit positions and the buffered ALU result record.
`default_nettype none

package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_RD_W-1:0]   rd;
    logic                  we;
  } alu_res_t;

endpackage

`default_nettype wire

// File: rtl/res_fifo.sv
// res_fifo: DEPTH-entry synchronous FIFO of alu_res_t with occupancy count and flush.
`default_nettype none

module res_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  alu_res_t wdata,
  output alu_res_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  alu_res_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // Storage is reset so the head is zero in reset and never X when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results toward writeback, owns the C/V/Z/N flag register.
`default_nettype none

module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] aluOut,
  input  logic              carry,
  input  logic              overflow,
  input  logic              zero,
  input  logic              neg,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  input  logic              in_fe,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_we,
  output logic              fwd_valid,
  output logic [3:0]        flags,
  output logic              iCarry
);

  alu_res_t   push_ent;
  alu_res_t   head;
  logic       full;
  logic       empty;
  logic       accept;
  logic [3:0] flags_q;

  // in_ready looks only at occupancy and flush, never at wb_ready.
  assign in_ready = ~full & ~flush;
  assign accept   = in_valid & in_ready;

  assign push_ent.data = aluOut;
  assign push_ent.rd   = in_rd;
  assign push_ent.we   = in_we;

  res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (wb_ready),
    .flush (flush),
    .wdata (push_ent),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign wb_valid  = ~empty;
  assign wb_data   = head.data;
  assign wb_rd     = head.rd;
  assign wb_we     = head.we;
  assign fwd_valid = wb_valid & head.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (accept && in_fe) begin
      flags_q[FLAG_C] <= carry;
      flags_q[FLAG_V] <= overflow;
      flags_q[FLAG_Z] <= zero;
      flags_q[FLAG_N] <= neg;
    end
  end

  assign flags  = flags_q;
  assign iCarry = flags_q[FLAG_C];

endmodule

`default_nettype wire
